// File: rtl/sop_stim_checker.sv
// Stimulus/response checker for the xy'+yz sum-of-products block.
// Sweeps {x,y,z} through 000..111, holds each vector for SETTLE_CYCLES, then samples f_i
// against the golden function and accumulates a saturating mismatch count.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stimulus parked at 000, waiting for start
// SETTLE | current vector driven, settle down-counter running
// SAMPLE | one cycle: compare f_i with golden, advance vector or pass
// FINISH | done pulse, pass flag computed, busy dropped
module sop_stim_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             x_o,
  output logic             y_o,
  output logic             z_o,
  input  logic             f_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_vld
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PASS_W = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [PASS_W-1:0] LAST_PASS   = PASS_W'(NUM_PASSES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, FINISH} state_t;

  state_t            state, state_nx;
  logic [2:0]        idx, idx_nx;
  logic [PASS_W-1:0] pass_cnt, pass_cnt_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              exp_f;
  logic              mismatch;

  assign exp_f    = (idx[2] & ~idx[1]) | (idx[1] & idx[0]);
  assign mismatch = (state == SAMPLE) && (f_i != exp_f);

  // Next-state, vector index, pass counter and settle timer.
  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    pass_cnt_nx = pass_cnt;
    cnt_nx      = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx    = SETTLE;
          idx_nx      = 3'd0;
          pass_cnt_nx = '0;
          cnt_nx      = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (cnt == '0) state_nx = SAMPLE;
        else           cnt_nx   = cnt - 1'b1;
      end
      SAMPLE: begin
        cnt_nx = SETTLE_LOAD;
        if (idx != 3'd7) begin
          idx_nx   = idx + 3'd1;
          state_nx = SETTLE;
        end else if (pass_cnt != LAST_PASS) begin
          idx_nx      = 3'd0;
          pass_cnt_nx = pass_cnt + 1'b1;
          state_nx    = SETTLE;
        end else begin
          state_nx = FINISH;
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State and sequencing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      pass_cnt <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      pass_cnt <= pass_cnt_nx;
      cnt      <= cnt_nx;
    end
  end

  // Registered stimulus and done pulse, aligned with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {x_o, y_o, z_o} <= 3'b000;
      done            <= 1'b0;
    end else begin
      {x_o, y_o, z_o} <= (state_nx == SETTLE || state_nx == SAMPLE) ? idx_nx : 3'b000;
      done            <= (state_nx == FINISH);
    end
  end

  // Result bookkeeping: cleared on an accepted start, held after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= 3'b000;
      first_fail_vld <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        busy           <= 1'b1;
        pass           <= 1'b0;
        err_count      <= '0;
        first_fail_vld <= 1'b0;
      end
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (!first_fail_vld) begin
          first_fail_vec <= idx;
          first_fail_vld <= 1'b1;
        end
      end
      if (state == FINISH) begin
        pass <= (err_count == '0);
        busy <= 1'b0;
      end
    end
  end

endmodule
